// File: rtl/addsub_accum_ctrl.sv
// Accumulate controller around an external combinational adder/subtractor.
// Commands arrive over a valid/ready handshake and are executed in one
// cycle. The response (accumulator, overflow, sticky flag, op count) is
// returned over a second valid/ready handshake. The adder inputs come
// straight from registers, so nothing on in_* reaches as_* in the same cycle.
module addsub_accum_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_mode,
    input  logic [WIDTH-1:0] as_result,
    input  logic             as_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_v,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             mode_reg, mode_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             out_v_reg, out_v_next;
    logic             sticky_reg, sticky_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // State register; reset drops any in-flight command or pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, handshake outputs and datapath next values.
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        data_next   = data_reg;
        mode_next   = mode_reg;
        acc_next    = acc_reg;
        out_v_next  = out_v_reg;
        sticky_next = sticky_reg;
        count_next  = count_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_next    = in_op;
                    data_next  = in_data;
                    // Mode is decoded at accept time so as_mode is a plain flop.
                    mode_next  = (in_op == OP_SUB);
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (op_reg)
                    OP_ADD, OP_SUB: begin
                        acc_next    = as_result;
                        out_v_next  = as_v;
                        sticky_next = sticky_reg | as_v;
                        if (count_reg != CNT_MAX) begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        acc_next   = data_reg;
                        out_v_next = 1'b0;
                    end
                    OP_CLR: begin
                        acc_next    = '0;
                        out_v_next  = 1'b0;
                        sticky_next = 1'b0;
                        count_next  = '0;
                    end
                endcase
                state_next = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: latched command, accumulator and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg     <= '0;
            data_reg   <= '0;
            mode_reg   <= 1'b0;
            acc_reg    <= '0;
            out_v_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            op_reg     <= op_next;
            data_reg   <= data_next;
            mode_reg   <= mode_next;
            acc_reg    <= acc_next;
            out_v_reg  <= out_v_next;
            sticky_reg <= sticky_next;
            count_reg  <= count_next;
        end
    end

    assign as_a       = acc_reg;
    assign as_b       = data_reg;
    assign as_mode    = mode_reg;
    assign out_acc    = acc_reg;
    assign out_v      = out_v_reg;
    assign ovf_sticky = sticky_reg;
    assign op_count   = count_reg;

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Bench for addsub_accum_ctrl: a behavioural adder/subtractor closes the loop,
// a table of commands with hand-computed results drives the main checks, and a
// scoreboard queue matches every response handshake against its expectation.
module tb_addsub_accum_ctrl;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic [7:0] as_a, as_b, as_result;
    logic       as_mode, as_v;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_acc;
    logic       out_v, ovf_sticky;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    addsub_accum_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .as_a(as_a), .as_b(as_b), .as_mode(as_mode),
        .as_result(as_result), .as_v(as_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_v(out_v), .ovf_sticky(ovf_sticky), .op_count(op_count)
    );

    // Reference combinational adder/subtractor with signed overflow.
    assign as_result = as_mode ? (as_a - as_b) : (as_a + as_b);
    assign as_v = as_mode ? ((as_a[7] != as_b[7]) && (as_result[7] != as_a[7]))
                          : ((as_a[7] == as_b[7]) && (as_result[7] != as_a[7]));

    typedef struct {
        logic [7:0] acc;
        logic       v;
        logic       st;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] acc;
        logic       v;
        logic       st;
        logic [7:0] cnt;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Model state for the model-driven sequences.
    logic [7:0] m_acc;
    logic       m_v, m_st;
    logic [7:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input logic [1:0] op, input logic [7:0] d);
        int sa, sd, r;
        sa = int'($signed(m_acc));
        sd = int'($signed(d));
        case (op)
            ADD, SUB: begin
                r     = (op == ADD) ? sa + sd : sa - sd;
                m_v   = (r > 127) || (r < -128);
                m_acc = 8'(r);
                m_st  = m_st | m_v;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            LOAD: begin m_acc = d; m_v = 1'b0; end
            default: begin m_acc = 8'h00; m_v = 1'b0; m_st = 1'b0; m_cnt = 8'h00; end
        endcase
    endfunction

    // Scoreboard consumer: one line per response handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got acc=%0h expected none", out_acc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp acc=%02h v=%0b sticky=%0b count=%0d (exp %02h %0b %0b %0d)",
                         out_acc, out_v, ovf_sticky, op_count,
                         mon_e.acc, mon_e.v, mon_e.st, mon_e.cnt);
                chk("resp_acc", 32'(out_acc), 32'(mon_e.acc));
                chk("resp_v", 32'(out_v), 32'(mon_e.v));
                chk("resp_sticky", 32'(ovf_sticky), 32'(mon_e.st));
                chk("resp_count", 32'(op_count), 32'(mon_e.cnt));
            end
        end
    end

    // Drive one command, check EXEC drive, latency and RESP hold behaviour.
    // While holding the response, a follow-up command (qop/qdata) is presented
    // and must not be accepted until the FSM is back in IDLE.
    task automatic send(input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] e_acc, input logic e_v, input logic e_st,
                        input logic [7:0] e_cnt, input int hold,
                        input logic [1:0] qop, input logic [7:0] qdata);
        int   waitc;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        waitc    = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.acc = e_acc; e.v = e_v; e.st = e_st; e.cnt = e_cnt;
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        chk("exec_out_valid", 32'(out_valid), 32'd0);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        chk("exec_as_mode", 32'(as_mode), 32'(op == SUB));
        chk("exec_as_b", 32'(as_b), 32'(data));
        @(posedge clk);
        #1;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_op    = qop;
            in_data  = qdata;
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_acc", 32'(out_acc), 32'(e_acc));
            chk("hold_out_v", 32'(out_v), 32'(e_v));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_resp_out_valid", 32'(out_valid), 32'd0);
        chk("after_resp_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t tab[15];

    initial begin
        int cyc, last, n;

        tab[0]  = '{LOAD, 8'h43, 8'h43, 1'b0, 1'b0, 8'd0};
        tab[1]  = '{ADD,  8'h81, 8'hC4, 1'b0, 1'b0, 8'd1};
        tab[2]  = '{LOAD, 8'h43, 8'h43, 1'b0, 1'b0, 8'd1};
        tab[3]  = '{SUB,  8'hC9, 8'h7A, 1'b0, 1'b0, 8'd2};
        tab[4]  = '{LOAD, 8'h7F, 8'h7F, 1'b0, 1'b0, 8'd2};
        tab[5]  = '{ADD,  8'h01, 8'h80, 1'b1, 1'b1, 8'd3};
        tab[6]  = '{ADD,  8'h01, 8'h81, 1'b0, 1'b1, 8'd4};
        tab[7]  = '{LOAD, 8'h80, 8'h80, 1'b0, 1'b1, 8'd4};
        tab[8]  = '{SUB,  8'h01, 8'h7F, 1'b1, 1'b1, 8'd5};
        tab[9]  = '{CLR,  8'h5A, 8'h00, 1'b0, 1'b0, 8'd0};
        tab[10] = '{SUB,  8'h05, 8'hFB, 1'b0, 1'b0, 8'd1};
        tab[11] = '{ADD,  8'h05, 8'h00, 1'b0, 1'b0, 8'd2};
        tab[12] = '{LOAD, 8'h80, 8'h80, 1'b0, 1'b0, 8'd2};
        tab[13] = '{ADD,  8'h80, 8'h00, 1'b1, 1'b1, 8'd3};
        tab[14] = '{CLR,  8'h00, 8'h00, 1'b0, 1'b0, 8'd0};

        // Reset state, checked while reset is still asserted.
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", 32'(out_acc), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            $display("cmd op=%0d data=%02h", tab[i].op, tab[i].data);
            send(tab[i].op, tab[i].data, tab[i].acc, tab[i].v, tab[i].st, tab[i].cnt,
                 0, ADD, 8'h00);
        end
        m_acc = 8'h00; m_v = 1'b0; m_st = 1'b0; m_cnt = 8'h00;

        // Response held for 5 cycles with a follow-up ADD 0x22 waiting.
        model_step(LOAD, 8'h55);
        $display("cmd op=%0d data=55 (response held)", LOAD);
        send(LOAD, 8'h55, m_acc, m_v, m_st, m_cnt, 5, ADD, 8'h22);
        model_step(ADD, 8'h22);
        $display("cmd op=%0d data=22 (queued)", ADD);
        send(ADD, 8'h22, m_acc, m_v, m_st, m_cnt, 0, ADD, 8'h00);

        // Back-to-back ADD 0x01 with out_ready held: 3-cycle cadence and
        // op_count saturation.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = ADD;
        in_data   = 8'h01;
        last = -1; n = 0; cyc = 0;
        while (n < 260 && cyc < 2000) begin
            cyc++;
            if (in_ready) begin
                exp_t e;
                model_step(ADD, 8'h01);
                e.acc = m_acc; e.v = m_v; e.st = m_st; e.cnt = m_cnt;
                exp_q.push_back(e);
                if (last >= 0) chk("cadence", 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
            end
            if (n < 260) @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_accepted", 32'(n), 32'd260);
        chk("b2b_count_sat", 32'(op_count), 32'hFF);
        chk("b2b_sticky", 32'(ovf_sticky), 32'(m_st));
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during EXEC of ADD 0x10: nothing comes back.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = ADD;
        in_data  = 8'h10;
        chk("rst_test_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_acc", 32'(out_acc), 32'd0);
        chk("async_v", 32'(out_v), 32'd0);
        chk("async_sticky", 32'(ovf_sticky), 32'd0);
        chk("async_count", 32'(op_count), 32'd0);
        chk("async_as_b", 32'(as_b), 32'd0);
        chk("async_as_mode", 32'(as_mode), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_resp", 32'(out_valid), 32'd0);
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
